// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared constants, types and helpers for the memory-access stage:
//   data width, funct3 load/store encodings, FSM state encodings, and
//   small pure functions for the alignment check and the store byte lanes.
//   No ports (package).
package mem_access_pkg;

    localparam int XLEN = 32;

    // funct3 encodings for loads/stores
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only the low two funct3 bits select the access size; bit 2 is the
    // unsigned flag and only matters for load extraction.
    // 00 = byte, 01 = half, anything else is treated as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate the datum across all lanes so the byte enables alone pick
    // the destination bytes.
    function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
//   Data-bus interface between the memory-access stage (master) and the
//   memory system (slave). Single outstanding request: req/gnt handshake
//   for the request phase, rvalid beat for read data or write ack.
//   Signals: req, we, addr, be, wdata (master -> slave);
//            gnt, rvalid, rdata (slave -> master).
interface mem_access_if;
    import mem_access_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align
//   Combinational load-data extraction: shifts the bus word so the
//   addressed byte/halfword lands in the low bits, then sign- or
//   zero-extends according to funct3. Shared with the future cache path.
//   Ports: rdata (bus word), addr (byte offset in word), funct3,
//          wb_data (write-back value).
module load_align
    import mem_access_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            MEM_B:   wb_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_BU:  wb_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MEM_H:   wb_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_HU:  wb_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: wb_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   Memory-access pipeline stage. Takes the EX result (ALU value or
//   effective address) and store data, runs at most one load/store on the
//   data bus, and emits one registered write-back beat per instruction.
//   Ports:
//     clk, rst          - clock, async active-high reset
//     in_*              - EX-side valid/ready handshake and operands
//     out_*             - write-back beat (valid pulse, data, rd, misaligned)
//     dbus              - data bus, master side
module mem_access
    import mem_access_pkg::*;
(
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_kill,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rd,

    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_misaligned,

    mem_access_if.master    dbus
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      offset_q, offset_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_mis_q, out_mis_d;

    logic [XLEN-1:0] load_data;
    logic            accept;
    logic            is_mem;

    load_align u_load_align (
        .rdata   (dbus.rdata),
        .addr    (offset_q),
        .funct3  (funct3_q),
        .wb_data (load_data)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready & ~in_kill;
    assign is_mem   = in_mem_read | in_mem_write;

    assign dbus.req   = (state_q == ST_REQ);
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.be    = be_q;
    assign dbus.wdata = wdata_q;

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_rd         = out_rd_q;
    assign out_misaligned = out_mis_q;

    // Next-state and write-back logic. Bus fields are only loaded on
    // acceptance so they stay frozen for the whole REQ phase.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        offset_d    = offset_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_mis_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_result;
                        out_rd_d    = in_rd;
                    end else if (is_misaligned(in_funct3[1:0], in_result[1:0])) begin
                        out_valid_d = 1'b1;
                        out_mis_d   = 1'b1;
                        out_data_d  = in_result;
                        out_rd_d    = in_rd;
                    end else begin
                        addr_d   = {in_result[XLEN-1:2], 2'b00};
                        offset_d = in_result[1:0];
                        funct3_d = in_funct3;
                        rd_d     = in_rd;
                        we_d     = in_mem_write;
                        be_d     = store_be(in_funct3[1:0], in_result[1:0]);
                        wdata_d  = in_mem_write ? store_wdata(in_funct3[1:0], in_rs2_data)
                                                : '0;
                        state_d  = ST_REQ;
                    end
                end
            end

            // rvalid coinciding with gnt belongs to no request yet, so it
            // is deliberately not looked at here.
            ST_REQ: begin
                if (dbus.gnt) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (dbus.rvalid) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    if (we_q) begin
                        out_data_d = '0;
                        out_rd_d   = '0;
                    end else begin
                        out_data_d = load_data;
                        out_rd_d   = rd_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and registered outputs; reset returns to IDLE at once,
    // abandoning any in-flight bus transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            offset_q    <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            offset_q    <= offset_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_mis_q   <= out_mis_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Directed self-checking bench for mem_access. Inputs change 1 ns after
//   a rising edge; outputs are sampled at the same point.
module tb_mem_access;
   import mem_access_pkg::*;

   logic            clk;
   logic            rst;
   logic            inValid;
   logic            inReady;
   logic            inKill;
   logic            inMemRead;
   logic            inMemWrite;
   logic [2:0]      inFunct3;
   logic [31:0]     inResult;
   logic [31:0]     inRs2Data;
   logic [4:0]      inRd;
   logic            outValid;
   logic [31:0]     outData;
   logic [4:0]      outRd;
   logic            outMisaligned;

   int assertCount;
   int failCount;

   mem_access_if dbusIf ();

   mem_access dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (inValid),
      .in_ready       (inReady),
      .in_kill        (inKill),
      .in_mem_read    (inMemRead),
      .in_mem_write   (inMemWrite),
      .in_funct3      (inFunct3),
      .in_result      (inResult),
      .in_rs2_data    (inRs2Data),
      .in_rd          (inRd),
      .out_valid      (outValid),
      .out_data       (outData),
      .out_rd         (outRd),
      .out_misaligned (outMisaligned),
      .dbus           (dbusIf.master)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle and land 1 ns past the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic kill, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] result,
                                input logic [31:0] rs2, input logic [4:0] dest);
      inValid    = valid;
      inKill     = kill;
      inMemRead  = rd;
      inMemWrite = wr;
      inFunct3   = f3;
      inResult   = result;
      inRs2Data  = rs2;
      inRd       = dest;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
   endtask

   // Grant immediately (with a stray rvalid beside it, which must be
   // ignored), then deliver the response after rvDelay empty cycles.
   task automatic runBus(input int rvDelay, input logic [31:0] rdata);
      dbusIf.gnt    = 1'b1;
      dbusIf.rvalid = 1'b1;
      dbusIf.rdata  = 32'hDEAD_BEEF;
      tick();
      dbusIf.gnt    = 1'b0;
      dbusIf.rvalid = 1'b0;
      for (int i = 0; i < rvDelay; i++) tick();
      dbusIf.rvalid = 1'b1;
      dbusIf.rdata  = rdata;
      tick();
      dbusIf.rvalid = 1'b0;
      dbusIf.rdata  = 32'h0;
   endtask

   // Accept a load, check its bus request, run the bus, check the beat
   task automatic loadCase(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [3:0] expBe, input logic [31:0] rdata,
                           input logic [31:0] expData, input logic [4:0] dest);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, f3, addr, 32'hFFFF_FFFF, dest);
      tick();
      idleInputs();
      checkOutput({tag, " req"},   {31'b0, dbusIf.req}, 32'h1);
      checkOutput({tag, " we"},    {31'b0, dbusIf.we},  32'h0);
      checkOutput({tag, " be"},    {28'b0, dbusIf.be},  {28'b0, expBe});
      checkOutput({tag, " wdata"}, dbusIf.wdata,        32'h0);
      runBus(0, rdata);
      checkOutput({tag, " valid"}, {31'b0, outValid},   32'h1);
      checkOutput({tag, " data"},  outData,             expData);
      checkOutput({tag, " rd"},    {27'b0, outRd},      {27'b0, dest});
   endtask

   initial begin
      assertCount   = 0;
      failCount     = 0;
      dbusIf.gnt    = 1'b0;
      dbusIf.rvalid = 1'b0;
      dbusIf.rdata  = 32'h0;
      idleInputs();

      // Reset values
      rst = 1'b1;
      tick();
      tick();
      checkOutput("rst out_valid", {31'b0, outValid},    32'h0);
      checkOutput("rst in_ready",  {31'b0, inReady},     32'h1);
      checkOutput("rst req",       {31'b0, dbusIf.req},  32'h0);
      checkOutput("rst out_data",  outData,              32'h0);
      checkOutput("rst addr",      dbusIf.addr,          32'h0);
      checkOutput("rst be",        {28'b0, dbusIf.be},   32'h0);
      rst = 1'b0;
      tick();

      // Non-memory op
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
      tick();
      idleInputs();
      checkOutput("alu valid", {31'b0, outValid},   32'h1);
      checkOutput("alu data",  outData,             32'h1234_5678);
      checkOutput("alu rd",    {27'b0, outRd},      32'd5);
      checkOutput("alu req",   {31'b0, dbusIf.req}, 32'h0);
      tick();
      checkOutput("alu pulse", {31'b0, outValid},   32'h0);

      // Back-to-back non-memory ops: one beat per cycle
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_00A1, 32'h0, 5'd1);
      tick();
      checkOutput("b2b first", outData, 32'h0000_00A1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_00B2, 32'h0, 5'd2);
      tick();
      idleInputs();
      checkOutput("b2b second valid", {31'b0, outValid}, 32'h1);
      checkOutput("b2b second data",  outData,           32'h0000_00B2);

      // SB to 0x103
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, MEM_B, 32'h0000_0103, 32'hAABB_CCDD, 5'd7);
      tick();
      idleInputs();
      checkOutput("sb req",      {31'b0, dbusIf.req}, 32'h1);
      checkOutput("sb we",       {31'b0, dbusIf.we},  32'h1);
      checkOutput("sb addr",     dbusIf.addr,         32'h0000_0100);
      checkOutput("sb be",       {28'b0, dbusIf.be},  32'h8);
      checkOutput("sb wdata",    dbusIf.wdata,        32'hDDDD_DDDD);
      checkOutput("sb in_ready", {31'b0, inReady},    32'h0);
      runBus(1, 32'h0);
      checkOutput("sb valid",    {31'b0, outValid},   32'h1);
      checkOutput("sb rd",       {27'b0, outRd},      32'h0);
      checkOutput("sb data",     outData,             32'h0);
      checkOutput("sb ready",    {31'b0, inReady},    32'h1);

      // SH to 0x102
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, MEM_H, 32'h0000_0102, 32'h1122_3344, 5'd8);
      tick();
      idleInputs();
      checkOutput("sh be",    {28'b0, dbusIf.be}, 32'hC);
      checkOutput("sh wdata", dbusIf.wdata,       32'h3344_3344);
      runBus(0, 32'h0);
      checkOutput("sh valid", {31'b0, outValid},  32'h1);

      // Loads with extraction
      loadCase("lb",  MEM_B,  32'h0000_0102, 4'b0100, 32'h0080_0000, 32'hFFFF_FF80, 5'd3);
      loadCase("lbu", MEM_BU, 32'h0000_0102, 4'b0100, 32'h0080_0000, 32'h0000_0080, 5'd3);
      loadCase("lhu", MEM_HU, 32'h0000_0102, 4'b1100, 32'h8001_0000, 32'h0000_8001, 5'd4);
      loadCase("lh",  MEM_H,  32'h0000_0100, 4'b0011, 32'h1234_8001, 32'hFFFF_8001, 5'd6);
      loadCase("lw",  MEM_W,  32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd9);

      // Misaligned LW 0x206
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MEM_W, 32'h0000_0206, 32'h0, 5'd10);
      tick();
      idleInputs();
      checkOutput("mis valid", {31'b0, outValid},      32'h1);
      checkOutput("mis flag",  {31'b0, outMisaligned}, 32'h1);
      checkOutput("mis data",  outData,                32'h0000_0206);
      checkOutput("mis req",   {31'b0, dbusIf.req},    32'h0);
      checkOutput("mis ready", {31'b0, inReady},       32'h1);
      tick();
      checkOutput("mis flag pulse", {31'b0, outMisaligned}, 32'h0);

      // Misaligned LH 0x101
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MEM_H, 32'h0000_0101, 32'h0, 5'd11);
      tick();
      idleInputs();
      checkOutput("mis lh flag", {31'b0, outMisaligned}, 32'h1);
      checkOutput("mis lh req",  {31'b0, dbusIf.req},    32'h0);

      // Grant held off for 3 cycles with another instruction presented
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, MEM_W, 32'h0000_0300, 32'h1122_3344, 5'd4);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0777, 32'h0, 5'd6);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall req",   {31'b0, dbusIf.req}, 32'h1);
         checkOutput("stall addr",  dbusIf.addr,         32'h0000_0300);
         checkOutput("stall be",    {28'b0, dbusIf.be},  32'hF);
         checkOutput("stall wdata", dbusIf.wdata,        32'h1122_3344);
         checkOutput("stall ready", {31'b0, inReady},    32'h0);
         checkOutput("stall beat",  {31'b0, outValid},   32'h0);
      end
      idleInputs();
      runBus(0, 32'h0);
      checkOutput("stall ack valid", {31'b0, outValid}, 32'h1);
      checkOutput("stall ack rd",    {27'b0, outRd},    32'h0);
      tick();
      checkOutput("stall no extra", {31'b0, outValid}, 32'h0);

      // Killed instruction produces no beat
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd12);
      tick();
      idleInputs();
      checkOutput("kill valid", {31'b0, outValid}, 32'h0);
      checkOutput("kill ready", {31'b0, inReady},  32'h1);

      // Reset while in RESP, then a late rvalid
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, MEM_W, 32'h0000_0400, 32'h0, 5'd2);
      tick();
      idleInputs();
      dbusIf.gnt = 1'b1;
      tick();
      dbusIf.gnt = 1'b0;
      checkOutput("resp ready", {31'b0, inReady}, 32'h0);
      rst = 1'b1;
      #2;
      checkOutput("async rst ready", {31'b0, inReady}, 32'h1);
      rst = 1'b0;
      dbusIf.rvalid = 1'b1;
      dbusIf.rdata  = 32'h1234_5678;
      tick();
      dbusIf.rvalid = 1'b0;
      checkOutput("late rvalid beat",  {31'b0, outValid}, 32'h0);
      checkOutput("late rvalid ready", {31'b0, inReady},  32'h1);
      tick();
      checkOutput("late rvalid beat2", {31'b0, outValid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the core: consumes the EX stage's result (effective address or ALU value) and store data, and runs a single-outstanding load/store transaction on the data bus. It presents one registered write-back beat per instruction. It sits between EX and write-back and stalls EX through a valid/ready handshake while a bus transaction is in flight.

## Interface
- `XLEN`, 32: data/address width (from `defines.v`).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: EX presents an instruction.
- `in_ready` out 1: stage can accept; equals (state == IDLE).
- `in_kill` in 1: squash the presented instruction (branch flush); an instruction presented with it is dropped.
- `in_mem_read` in 1: instruction is a load.
- `in_mem_write` in 1: instruction is a store. Never set together with `in_mem_read`.
- `in_funct3` in 3: load/store width and sign.
- `in_result` in XLEN: EX result, either the effective address or the ALU value.
- `in_rs2_data` in XLEN: store data.
- `in_rd` in 5: destination register index.
- `out_valid` out 1: one-cycle write-back beat.
- `out_data` out XLEN: load data, ALU value, or faulting address.
- `out_rd` out 5: destination index.
- `out_misaligned` out 1: misaligned access; no bus activity took place.
- `dbus_req` out 1: bus request.
- `dbus_we` out 1: 1 = write.
- `dbus_addr` out XLEN: word-aligned address.
- `dbus_be` out 4: byte enables.
- `dbus_wdata` out XLEN: write data.
- `dbus_gnt` in 1: request accepted this cycle.
- `dbus_rvalid` in 1: response/ack beat.
- `dbus_rdata` in XLEN: read data.

## Operation

**Acceptance**
- An instruction is accepted when `in_valid & in_ready & !in_kill`.
- Everything else is ignored and produces no `out_valid`.

**FSM states: IDLE, REQ, RESP.**
- IDLE, accepting a non-memory op: latch `in_result`/`in_rd`, then `out_valid`=1 next cycle with `out_data`=`in_result`. Stay in IDLE.
- IDLE, accepting a memory op that is misaligned (halfword with addr[0]=1, word with addr[1:0]≠0): no request; `out_valid`=1 and `out_misaligned`=1 next cycle, `out_data`=address. Stay in IDLE.
- IDLE, accepting any other memory op: latch address, funct3, rd and formatted write data. Go to REQ.
- REQ: `dbus_req`=1. `dbus_we`, `dbus_addr`, `dbus_be` and `dbus_wdata` are held stable until the cycle `dbus_gnt`=1, then go to RESP. If `dbus_rvalid` arrives in the same cycle as `dbus_gnt`, it is ignored.
- RESP: `dbus_req`=0. Wait for `dbus_rvalid`, then return to IDLE.
  - Next cycle `out_valid`=1.
  - Loads: `out_data` is the extracted load data.
  - Stores: `out_rd`=0 and `out_data`=0; stores are acknowledged by `dbus_rvalid` too.
- `dbus_rvalid` in IDLE or REQ is ignored.

**Address and store formatting**
- `dbus_addr` = {addr[XLEN-1:2], 2'b00}.
- funct3 000 (byte): be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
- funct3 001 (half): be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated ×2.
- funct3 010 (word): be = 4'b1111.
- funct3 011/110/111 are treated as word.
- Loads drive `dbus_be` with the same pattern and `dbus_wdata`=0.

**Load extraction**
- Shift `dbus_rdata` right by 8·addr[1:0].
- 000: sign-extend bits [7:0]. 100: zero-extend bits [7:0].
- 001: sign-extend bits [15:0]. 101: zero-extend bits [15:0].
- Word: no extension.

## Timing
- Reset values: state IDLE; `out_valid`, `out_data`, `out_rd`, `out_misaligned`, `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_be` and `dbus_wdata` all 0; `in_ready`=1.
- Outputs are registered; `in_ready` is decoded directly from state.
- Non-memory or misaligned op accepted at cycle T: `out_valid` at T+1. Back-to-back acceptance gives one beat per cycle.
- Memory op accepted at T with `dbus_gnt` at T+1 and `dbus_rvalid` at T+2: `out_valid` at T+3, `in_ready` low during T+1..T+2, next accept at T+3. Each wait cycle on gnt or rvalid adds one cycle.
- `out_valid` is a single-cycle pulse; write-back never back-pressures.
- `in_kill` does not abort a transaction that has already been accepted.
- Reset asserted mid-transaction forces IDLE immediately. Any late `dbus_rvalid` is discarded.

## Structure
- `defines.v` gains:
  - funct3 constants MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU;
  - FSM state encodings ST_IDLE, ST_REQ, ST_RESP.
- One combinational sub-module `load_align`, with inputs rdata, addr[1:0] and funct3, and output write-back data. It is reused by a future cache path.
- Store formatting stays inline.

## Test plan
- Non-memory op, `in_result`=0x1234_5678, rd=5 -> `out_valid` at T+1 with `out_data`=0x1234_5678, `out_rd`=5, no `dbus_req`.
- SB addr 0x103, rs2 0xAABB_CCDD -> `dbus_addr`=0x100, `dbus_be`=4'b1000, `dbus_wdata`=0xDDDD_DDDD, `dbus_we`=1; `out_rd`=0 after rvalid.
- LB addr 0x102, rdata 0x0080_0000 -> `out_data`=0xFFFF_FF80; the same access as LBU -> 0x0000_0080; LHU addr 0x102 with rdata 0x8001_0000 -> 0x0000_8001.
- LW addr 0x206 -> `out_misaligned`=1, `out_data`=0x206 at T+1, `dbus_req` stays 0.
- `dbus_gnt` held low for 3 cycles -> `dbus_req`, `dbus_addr`, `dbus_be` and `dbus_wdata` stable throughout; `in_ready`=0; a presented `in_valid` is not accepted.
- `in_valid` with `in_kill`=1 -> no beat. Reset while in RESP, then `dbus_rvalid` -> no `out_valid`, `in_ready`=1.
